// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the MEM-stage writeback buffer.
// An entry holds one dirty word keyed by its 30-bit word address.
package wbuf_pkg;

  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    logic [31:0] data;
  } wbuf_entry_t;

  // Byte address to word address; the byte offset is irrelevant to the buffer.
  function automatic logic [29:0] word_addr(input logic [31:0] addr);
    return addr[31:WORD_LSB];
  endfunction

endpackage

// File: rtl/wbuf_match.sv
// Parallel comparison of one word address against every buffer entry.
// Produces one match bit per valid entry holding that word.
module wbuf_match #(
  parameter int DEPTH = 4
) (
  input  logic [29:0]         i_key,
  input  logic [DEPTH-1:0]    i_valid,
  input  logic [DEPTH*30-1:0] i_waddrs,
  output logic [DEPTH-1:0]    o_match
);

  // Per-entry compare, qualified by the entry valid bit
  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_valid[i] && (i_waddrs[i*30 +: 30] == i_key);
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Word-granular write buffer between the cache and data memory: absorbs and
// coalesces dirty-word evictions, drains them in order, and forwards to refills.
module writeback_buffer
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [31:0]      wb_addr,
  input  logic [31:0]      wb_data,
  output logic             wb_ready,
  input  logic             fetch,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_hit,
  output logic [31:0]      fetch_data,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  wbuf_entry_t      r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_deq;
  logic             w_acc;
  logic             w_coalesce;
  logic             w_alloc;
  logic [PTR_W-1:0] w_co_idx;
  logic [29:0]      w_wb_word;
  logic [29:0]      w_fe_word;
  logic [DEPTH-1:0]    w_valid_vec;
  logic [DEPTH*30-1:0] w_waddrs;
  logic [DEPTH-1:0]    w_head_oh;
  logic [DEPTH-1:0]    w_co_match;
  logic [DEPTH-1:0]    w_co_eff;
  logic [DEPTH-1:0]    w_fe_match;
  logic [DEPTH-1:0]    w_fe_pref;
  logic [DEPTH-1:0]    w_fe_sel;
  logic [31:0]      w_fe_entry_data;
  logic             w_wb_fwd;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_wb_word = word_addr(wb_addr);
  assign w_fe_word = word_addr(fetch_addr);
  assign w_head_oh = {{(DEPTH-1){1'b0}}, 1'b1} << r_head;

  assign wb_ready  = !w_full;
  assign mem_we    = !w_empty;
  assign mem_addr  = w_empty ? 32'h0 : {r_entries[r_head].waddr, 2'b00};
  assign mem_wd    = w_empty ? 32'h0 : r_entries[r_head].data;
  assign occupancy = r_count;

  assign w_deq     = mem_we && mem_ready;
  assign w_acc     = wb_valid && wb_ready;

  // Flatten entry keys for the two match units
  always_comb begin
    w_valid_vec = '0;
    w_waddrs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i]         = r_entries[i].valid;
      w_waddrs[i*30 +: 30]   = r_entries[i].waddr;
    end
  end

  wbuf_match #(.DEPTH(DEPTH)) u_match_coalesce (
    .i_key    (w_wb_word),
    .i_valid  (w_valid_vec),
    .i_waddrs (w_waddrs),
    .o_match  (w_co_match)
  );

  wbuf_match #(.DEPTH(DEPTH)) u_match_fetch (
    .i_key    (w_fe_word),
    .i_valid  (w_valid_vec),
    .i_waddrs (w_waddrs),
    .o_match  (w_fe_match)
  );

  // A head leaving this edge cannot absorb new data; the word gets a fresh entry
  assign w_co_eff   = w_co_match & ~(w_deq ? w_head_oh : {DEPTH{1'b0}});
  assign w_coalesce = |w_co_eff;
  assign w_alloc    = w_acc && !w_coalesce;

  // Encode the (unique) coalescing entry
  always_comb begin
    w_co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_co_idx = w_co_eff[i] ? PTR_W'(i) : w_co_idx;
    end
  end

  // Newer entries win over the head when both hold the refill word
  assign w_fe_pref = w_fe_match & ~w_head_oh;
  assign w_fe_sel  = (|w_fe_pref) ? w_fe_pref : w_fe_match;
  assign w_wb_fwd  = wb_valid && (w_wb_word == w_fe_word);

  // Select forwarded entry data
  always_comb begin
    w_fe_entry_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fe_entry_data = w_fe_entry_data | (w_fe_sel[i] ? r_entries[i].data : 32'h0);
    end
  end

  // Refill lookup: in-flight writeback first, then buffered entries
  always_comb begin
    fetch_hit  = 1'b0;
    fetch_data = 32'h0;
    if (!fetch) begin
      fetch_hit  = 1'b0;
      fetch_data = 32'h0;
    end else if (w_wb_fwd) begin
      fetch_hit  = 1'b1;
      fetch_data = wb_data;
    end else if (|w_fe_match) begin
      fetch_hit  = 1'b1;
      fetch_data = w_fe_entry_data;
    end else begin
      fetch_hit  = 1'b0;
      fetch_data = 32'h0;
    end
  end

  // Buffer state: drain at head, allocate at tail or coalesce in place
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_W'(1);
      end
      if (w_acc && w_coalesce) begin
        r_entries[w_co_idx].data <= wb_data;
      end else if (w_alloc) begin
        r_entries[r_tail] <= '{valid: 1'b1, waddr: w_wb_word, data: wb_data};
        r_tail            <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_deq);
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Randomized plus directed bench for writeback_buffer, checked by a
// scoreboard against a queue-based model of the buffer contents.
module tb_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid;
  logic [31:0]      wb_addr;
  logic [31:0]      wb_data;
  logic             wb_ready;
  logic             fetch;
  logic [31:0]      fetch_addr;
  logic             fetch_hit;
  logic [31:0]      fetch_data;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wd;
  logic             mem_ready;
  logic [CNT_W-1:0] occupancy;

  writeback_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .fetch(fetch), .fetch_addr(fetch_addr), .fetch_hit(fetch_hit),
    .fetch_data(fetch_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_ready(mem_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [29:0] w; logic [31:0] d; } ent_t;
  typedef struct { logic rdy; logic [CNT_W-1:0] occ; logic we; logic [31:0] ma; logic [31:0] md;
                   logic fh; logic [31:0] fd; } stat_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  ent_t  m_q[$];
  stat_t stat_q[$];
  wr_t   wr_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares presented outputs and memory writes against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stat_q.size() > 0) begin
          stat_t s;
          s = stat_q.pop_front();
          chk("wb_ready",   {31'h0, wb_ready},  {31'h0, s.rdy});
          chk("occupancy",  32'(occupancy),     32'(s.occ));
          chk("mem_we",     {31'h0, mem_we},    {31'h0, s.we});
          chk("mem_addr",   mem_addr,           s.ma);
          chk("mem_wd",     mem_wd,             s.md);
          chk("fetch_hit",  {31'h0, fetch_hit}, {31'h0, s.fh});
          chk("fetch_data", fetch_data,         s.fd);
        end
        if (mem_we === 1'b1 && mem_ready && !rst) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            chk("write_addr", mem_addr, w.a);
            chk("write_data", mem_wd,   w.d);
          end
        end
      end
    end
  end

  // One cycle: drive inputs, predict outputs, then advance the model at the edge
  task automatic step(input logic t_rst, input logic t_wbv, input logic [31:0] t_wba,
                      input logic [31:0] t_wbd, input logic t_fetch, input logic [31:0] t_fa,
                      input logic t_mr);
    stat_t s;
    int    n;
    bit    deq, acc, co;
    rst = t_rst; wb_valid = t_wbv; wb_addr = t_wba; wb_data = t_wbd;
    fetch = t_fetch; fetch_addr = t_fa; mem_ready = t_mr;
    n     = m_q.size();
    s.rdy = (n < DEPTH);
    s.occ = CNT_W'(n);
    s.we  = (n > 0);
    s.ma  = (n > 0) ? {m_q[0].w, 2'b00} : 32'h0;
    s.md  = (n > 0) ? m_q[0].d : 32'h0;
    s.fh  = 1'b0;
    s.fd  = 32'h0;
    if (t_fetch) begin
      if (t_wbv && t_wba[31:2] == t_fa[31:2]) begin
        s.fh = 1'b1; s.fd = t_wbd;
      end else begin
        for (int i = n - 1; i >= 0; i--) begin
          if (!s.fh && m_q[i].w == t_fa[31:2]) begin
            s.fh = 1'b1; s.fd = m_q[i].d;
          end
        end
      end
    end
    stat_q.push_back(s);
    if (!t_rst && n > 0 && t_mr) wr_q.push_back('{a: {m_q[0].w, 2'b00}, d: m_q[0].d});
    @(posedge clk);
    if (t_rst) begin
      m_q.delete();
    end else begin
      deq = (n > 0) && t_mr;
      acc = t_wbv && (n < DEPTH);
      co  = 1'b0;
      if (acc) begin
        for (int i = (deq ? 1 : 0); i < n; i++) begin
          if (m_q[i].w == t_wba[31:2]) begin
            m_q[i].d = t_wbd; co = 1'b1;
          end
        end
      end
      if (deq) void'(m_q.pop_front());
      if (acc && !co) m_q.push_back('{w: t_wba[31:2], d: t_wbd});
    end
    #2;
  endtask

  task automatic wb(input logic [31:0] a, input logic [31:0] d, input logic mr);
    step(1'b0, 1'b1, a, d, 1'b0, 32'h0, mr);
  endtask

  task automatic idle(input logic mr, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, mr);
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_addr = 32'h0; wb_data = 32'h0;
    fetch = 1'b0; fetch_addr = 32'h0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b1;
    // Basic accept then drain
    idle(1'b0, 1);
    wb(32'h100, 32'hAAAA, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);
    // Fill, hold while full, wrap
    wb(32'h10, 32'h11, 1'b0); wb(32'h20, 32'h22, 1'b0);
    wb(32'h30, 32'h33, 1'b0); wb(32'h40, 32'h44, 1'b0);
    wb(32'h50, 32'h55, 1'b0); wb(32'h50, 32'h55, 1'b0);
    wb(32'h50, 32'h55, 1'b1);
    wb(32'h50, 32'h55, 1'b0);
    idle(1'b1, 6);
    // Coalesce
    wb(32'h200, 32'h1, 1'b0); wb(32'h203, 32'h2, 1'b0);
    idle(1'b1, 2);
    // Forwarding
    wb(32'h300, 32'h5, 1'b0);
    step(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b1, 32'h300, 32'h9, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h304, 1'b0);
    step(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h300, 1'b0);
    idle(1'b1, 2);
    // Head dequeue with same-word writeback
    wb(32'h400, 32'h3, 1'b0);
    step(1'b0, 1'b1, 32'h400, 32'h7, 1'b1, 32'h400, 1'b1);
    idle(1'b0, 1);
    idle(1'b1, 2);
    // Reset with pending entries and a same-cycle writeback
    wb(32'h500, 32'h1, 1'b0); wb(32'h504, 32'h2, 1'b0); wb(32'h508, 32'h3, 1'b0);
    step(1'b1, 1'b1, 32'h50C, 32'h4, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 3);
    // Randomized traffic on a small word pool to provoke coalescing and hits
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, fa;
      a  = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      fa = 32'h1000 + 32'($urandom_range(0, 8)) * 32'd4 + 32'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), a, $urandom(),
           $urandom_range(0, 1) == 1, fa, ($urandom_range(0, 2) == 0));
    end
    idle(1'b1, 8);
    @(negedge clk);
    mon_en = 1'b0;
    chk("writes_outstanding", 32'(wr_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
